// File: rtl/id_ex_pipe_reg_if.sv
// ID/EX stage bundle: decode-side handshake and payload in, execute-side handshake and payload out.
// The pipeline register itself attaches through the slave modport.
interface id_ex_pipe_reg_if #(
    parameter int DATA_W  = 32,
    parameter int ALUOP_W = 5,
    parameter int CNT_W   = 16
);
    logic               Flush;
    logic               ID_Valid;
    logic               ID_Ready;
    logic [DATA_W-1:0]  InstructionIn;
    logic [DATA_W-1:0]  PCResultIn;
    logic [DATA_W-1:0]  ReadData1In;
    logic [DATA_W-1:0]  ReadData2In;
    logic [DATA_W-1:0]  SignExtendOutIn;
    logic [ALUOP_W-1:0] ALUInstructionIn;
    logic               RegWriteIn;
    logic               RegDstIn;
    logic               InputA_MuxSignalIn;
    logic               InputB_MuxSignalIn;
    logic               EX_Valid;
    logic               EX_Ready;
    logic [DATA_W-1:0]  EX_Instruction;
    logic [DATA_W-1:0]  EX_PCResult;
    logic [DATA_W-1:0]  EX_ReadData1;
    logic [DATA_W-1:0]  EX_ReadData2;
    logic [DATA_W-1:0]  EX_SignExtendOut;
    logic [ALUOP_W-1:0] EX_ALUInstruction;
    logic               EX_RegWrite;
    logic               EX_RegDst;
    logic               EX_InputA_MuxSignal;
    logic               EX_InputB_MuxSignal;
    logic [CNT_W-1:0]   EX_StallCount;

    modport master (
        output Flush, ID_Valid, InstructionIn, PCResultIn, ReadData1In, ReadData2In,
               SignExtendOutIn, ALUInstructionIn, RegWriteIn, RegDstIn,
               InputA_MuxSignalIn, InputB_MuxSignalIn, EX_Ready,
        input  ID_Ready, EX_Valid, EX_Instruction, EX_PCResult, EX_ReadData1, EX_ReadData2,
               EX_SignExtendOut, EX_ALUInstruction, EX_RegWrite, EX_RegDst,
               EX_InputA_MuxSignal, EX_InputB_MuxSignal, EX_StallCount
    );

    modport slave (
        input  Flush, ID_Valid, InstructionIn, PCResultIn, ReadData1In, ReadData2In,
               SignExtendOutIn, ALUInstructionIn, RegWriteIn, RegDstIn,
               InputA_MuxSignalIn, InputB_MuxSignalIn, EX_Ready,
        output ID_Ready, EX_Valid, EX_Instruction, EX_PCResult, EX_ReadData1, EX_ReadData2,
               EX_SignExtendOut, EX_ALUInstruction, EX_RegWrite, EX_RegDst,
               EX_InputA_MuxSignal, EX_InputB_MuxSignal, EX_StallCount
    );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with valid/ready handshake, two-entry skid buffer (main + skid),
// flush-driven bubble injection and a saturating stall counter.
module id_ex_pipe_reg #(
    parameter int DATA_W  = 32,
    parameter int ALUOP_W = 5,
    parameter int CNT_W   = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    id_ex_pipe_reg_if.slave   Bus
);

    typedef struct packed {
        logic [DATA_W-1:0]  instruction;
        logic [DATA_W-1:0]  pcResult;
        logic [DATA_W-1:0]  readData1;
        logic [DATA_W-1:0]  readData2;
        logic [DATA_W-1:0]  signExtendOut;
        logic [ALUOP_W-1:0] aluInstruction;
        logic               regWrite;
        logic               regDst;
        logic               inputAMux;
        logic               inputBMux;
    } bundle_t;

    localparam int               BUNDLE_W = $bits(bundle_t);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic       mValid_r;
    logic       sValid_r;
    bundle_t    mData_r;
    bundle_t    sData_r;
    logic [CNT_W-1:0] stallCnt_r;

    bundle_t    inBundle_s;
    logic       idReady_s;
    logic       accept_s;
    logic       drain_s;
    logic       mFree_s;

    assign inBundle_s.instruction    = Bus.InstructionIn;
    assign inBundle_s.pcResult       = Bus.PCResultIn;
    assign inBundle_s.readData1      = Bus.ReadData1In;
    assign inBundle_s.readData2      = Bus.ReadData2In;
    assign inBundle_s.signExtendOut  = Bus.SignExtendOutIn;
    assign inBundle_s.aluInstruction = Bus.ALUInstructionIn;
    assign inBundle_s.regWrite       = Bus.RegWriteIn;
    assign inBundle_s.regDst         = Bus.RegDstIn;
    assign inBundle_s.inputAMux      = Bus.InputA_MuxSignalIn;
    assign inBundle_s.inputBMux      = Bus.InputB_MuxSignalIn;

    // Ready depends only on the skid flag, never on EX_Ready, to break the back-pressure path.
    assign idReady_s = ~sValid_r & ~Reset;
    assign accept_s  = Bus.ID_Valid & idReady_s;
    assign drain_s   = mValid_r & Bus.EX_Ready;
    assign mFree_s   = ~mValid_r | drain_s;

    // Main/skid entry update: reset, then flush, then skid-to-main refill, then capture.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            mValid_r <= 1'b0;
            sValid_r <= 1'b0;
            mData_r  <= bundle_t'({BUNDLE_W{1'b0}});
            sData_r  <= bundle_t'({BUNDLE_W{1'b0}});
        end else if (Bus.Flush) begin
            mValid_r <= 1'b0;
            sValid_r <= 1'b0;
        end else if (mFree_s && sValid_r) begin
            mValid_r <= 1'b1;
            mData_r  <= sData_r;
            sValid_r <= 1'b0;
        end else if (mFree_s) begin
            mValid_r <= accept_s;
            if (accept_s) begin
                mData_r <= inBundle_s;
            end else begin
                mData_r <= mData_r;
            end
        end else if (accept_s) begin
            sValid_r <= 1'b1;
            sData_r  <= inBundle_s;
        end else begin
            mValid_r <= mValid_r;
            sValid_r <= sValid_r;
        end
    end

    // Stall counter: cycles the execute side refuses a valid bundle, saturating at all-ones.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            stallCnt_r <= {CNT_W{1'b0}};
        end else if (mValid_r && !Bus.EX_Ready && !Bus.Flush && (stallCnt_r != CNT_MAX)) begin
            stallCnt_r <= stallCnt_r + CNT_ONE;
        end else begin
            stallCnt_r <= stallCnt_r;
        end
    end

    assign Bus.ID_Ready            = idReady_s;
    assign Bus.EX_Valid            = mValid_r;
    assign Bus.EX_Instruction      = mData_r.instruction;
    assign Bus.EX_PCResult         = mData_r.pcResult;
    assign Bus.EX_ReadData1        = mData_r.readData1;
    assign Bus.EX_ReadData2        = mData_r.readData2;
    assign Bus.EX_SignExtendOut    = mData_r.signExtendOut;
    assign Bus.EX_ALUInstruction   = mData_r.aluInstruction;
    // Control bits are forced low in a bubble so a stale entry can never write back.
    assign Bus.EX_RegWrite         = mData_r.regWrite  & mValid_r;
    assign Bus.EX_RegDst           = mData_r.regDst    & mValid_r;
    assign Bus.EX_InputA_MuxSignal = mData_r.inputAMux & mValid_r;
    assign Bus.EX_InputB_MuxSignal = mData_r.inputBMux & mValid_r;
    assign Bus.EX_StallCount       = stallCnt_r;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg: directed scenarios plus randomized traffic
// compared against a depth-2 FIFO reference model.
module tb_id_ex_pipe_reg;

    localparam int DW      = 32;
    localparam int AW      = 5;
    localparam int CW      = 4;
    localparam int CNT_MAX = 15;

    typedef struct packed {
        logic [DW-1:0] instr;
        logic [DW-1:0] pc;
        logic [DW-1:0] rd1;
        logic [DW-1:0] rd2;
        logic [DW-1:0] sext;
        logic [AW-1:0] alu;
        logic          rw;
        logic          rdst;
        logic          ma;
        logic          mb;
    } bundle_t;

    logic    Clk;
    logic    Reset;
    int      checks;
    int      failures;
    bundle_t q[$];
    int      cntModel;
    bundle_t curIn;
    bundle_t zeroB;

    id_ex_pipe_reg_if #(.DATA_W(DW), .ALUOP_W(AW), .CNT_W(CW)) bus ();

    id_ex_pipe_reg #(.DATA_W(DW), .ALUOP_W(AW), .CNT_W(CW)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Bus   (bus)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    function automatic bundle_t rand_bundle();
        bundle_t b;
        b.instr = $urandom;
        b.pc    = $urandom;
        b.rd1   = $urandom;
        b.rd2   = $urandom;
        b.sext  = $urandom;
        b.alu   = AW'($urandom);
        b.rw    = 1'($urandom);
        b.rdst  = 1'($urandom);
        b.ma    = 1'($urandom);
        b.mb    = 1'($urandom);
        return b;
    endfunction

    task automatic drive(input bundle_t b, input logic v);
        curIn                  = b;
        bus.ID_Valid           = v;
        bus.InstructionIn      = b.instr;
        bus.PCResultIn         = b.pc;
        bus.ReadData1In        = b.rd1;
        bus.ReadData2In        = b.rd2;
        bus.SignExtendOutIn    = b.sext;
        bus.ALUInstructionIn   = b.alu;
        bus.RegWriteIn         = b.rw;
        bus.RegDstIn           = b.rdst;
        bus.InputA_MuxSignalIn = b.ma;
        bus.InputB_MuxSignalIn = b.mb;
    endtask

    function automatic bundle_t observed();
        bundle_t b;
        b.instr = bus.EX_Instruction;
        b.pc    = bus.EX_PCResult;
        b.rd1   = bus.EX_ReadData1;
        b.rd2   = bus.EX_ReadData2;
        b.sext  = bus.EX_SignExtendOut;
        b.alu   = bus.EX_ALUInstruction;
        b.rw    = bus.EX_RegWrite;
        b.rdst  = bus.EX_RegDst;
        b.ma    = bus.EX_InputA_MuxSignal;
        b.mb    = bus.EX_InputB_MuxSignal;
        return b;
    endfunction

    // One clock: the model is a FIFO of at most two bundles whose head is what execute sees.
    task automatic step();
        bit room;
        room = (q.size() < 2) && !Reset;
        @(posedge Clk);
        if (Reset) begin
            q.delete();
            cntModel = 0;
        end else if (bus.Flush) begin
            q.delete();
        end else begin
            if (q.size() > 0 && !bus.EX_Ready && cntModel < CNT_MAX) cntModel = cntModel + 1;
            if (q.size() > 0 && bus.EX_Ready) void'(q.pop_front());
            if (bus.ID_Valid && room) q.push_back(curIn);
        end
        #1;
    endtask

    task automatic test_reset();
        bundle_t b;
        Reset = 1'b1;
        b = rand_bundle();
        b.pc = 32'h0000_1234;
        b.rw = 1'b1;
        drive(b, 1'b1);
        bus.EX_Ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus.EX_Valid !== 1'b0) begin failures++; $display("FAIL reset_valid cyc=%0d got=%b exp=0", i, bus.EX_Valid); end
            checks++;
            if (bus.ID_Ready !== 1'b0) begin failures++; $display("FAIL reset_ready cyc=%0d got=%b exp=0", i, bus.ID_Ready); end
            checks++;
            if (observed() !== zeroB) begin failures++; $display("FAIL reset_payload cyc=%0d got=%h exp=0", i, observed()); end
            checks++;
            if (bus.EX_StallCount !== 4'd0) begin failures++; $display("FAIL reset_count cyc=%0d got=%0d exp=0", i, bus.EX_StallCount); end
        end
        Reset = 1'b0;
        drive(b, 1'b0);
        #1;
        checks++;
        if (bus.ID_Ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%b exp=1", bus.ID_Ready); end
        step();
        checks++;
        if (bus.EX_Valid !== 1'b0) begin failures++; $display("FAIL reset_no_capture got=%b exp=0", bus.EX_Valid); end
    endtask

    task automatic test_streaming();
        bundle_t b;
        bus.EX_Ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b = rand_bundle();
            b.pc = 32'(i * 4);
            drive(b, 1'b1);
            step();
            checks++;
            if (bus.EX_Valid !== 1'b1 || bus.EX_PCResult !== 32'(i * 4)) begin
                failures++; $display("FAIL stream_pc idx=%0d got=%b/%h exp=1/%h", i, bus.EX_Valid, bus.EX_PCResult, 32'(i * 4));
            end
            checks++;
            if (observed() !== b) begin failures++; $display("FAIL stream_bundle idx=%0d got=%h exp=%h", i, observed(), b); end
        end
        drive(b, 1'b0);
        step();
        checks++;
        if (bus.EX_Valid !== 1'b0) begin failures++; $display("FAIL stream_end_valid got=%b exp=0", bus.EX_Valid); end
    endtask

    task automatic test_backpressure();
        bundle_t b;
        logic [31:0] pcs [3];
        pcs[0] = 32'h10; pcs[1] = 32'h14; pcs[2] = 32'h18;
        Reset = 1'b1;
        drive(rand_bundle(), 1'b0);
        step();
        Reset = 1'b0;
        bus.EX_Ready = 1'b1;
        b = rand_bundle(); b.pc = pcs[0]; drive(b, 1'b1);
        step();
        checks++;
        if (bus.EX_PCResult !== 32'h10 || bus.EX_Valid !== 1'b1) begin failures++; $display("FAIL bp_first got=%b/%h exp=1/10", bus.EX_Valid, bus.EX_PCResult); end
        bus.EX_Ready = 1'b0;
        b = rand_bundle(); b.pc = pcs[1]; drive(b, 1'b1);
        step();
        checks++;
        if (bus.ID_Ready !== 1'b0) begin failures++; $display("FAIL bp_skid_ready got=%b exp=0", bus.ID_Ready); end
        b = rand_bundle(); b.pc = pcs[2]; drive(b, 1'b1);
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (bus.EX_PCResult !== 32'h10 || bus.EX_Valid !== 1'b1 || bus.ID_Ready !== 1'b0) begin
                failures++; $display("FAIL bp_hold cyc=%0d got=%b/%h/%b exp=1/10/0", i, bus.EX_Valid, bus.EX_PCResult, bus.ID_Ready);
            end
        end
        checks++;
        if (bus.EX_StallCount !== 4'd3) begin failures++; $display("FAIL bp_count got=%0d exp=3", bus.EX_StallCount); end
        bus.EX_Ready = 1'b1;
        step();
        checks++;
        if (bus.EX_PCResult !== 32'h14 || bus.ID_Ready !== 1'b1) begin failures++; $display("FAIL bp_second got=%h/%b exp=14/1", bus.EX_PCResult, bus.ID_Ready); end
        step();
        checks++;
        if (bus.EX_PCResult !== 32'h18 || bus.EX_Valid !== 1'b1) begin failures++; $display("FAIL bp_third got=%b/%h exp=1/18", bus.EX_Valid, bus.EX_PCResult); end
        drive(b, 1'b0);
        step();
        checks++;
        if (bus.EX_Valid !== 1'b0 || bus.EX_StallCount !== 4'd3) begin failures++; $display("FAIL bp_end got=%b/%0d exp=0/3", bus.EX_Valid, bus.EX_StallCount); end
    endtask

    task automatic test_flush();
        bundle_t b;
        bus.EX_Ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            b = rand_bundle(); b.rw = 1'b1; drive(b, 1'b1);
            step();
        end
        checks++;
        if (bus.EX_Valid !== 1'b1 || bus.EX_RegWrite !== 1'b1 || bus.ID_Ready !== 1'b0) begin
            failures++; $display("FAIL flush_fill got=%b/%b/%b exp=1/1/0", bus.EX_Valid, bus.EX_RegWrite, bus.ID_Ready);
        end
        b = rand_bundle(); b.rw = 1'b1; drive(b, 1'b1);
        bus.Flush = 1'b1;
        step();
        bus.Flush = 1'b0;
        checks++;
        if (bus.EX_Valid !== 1'b0 || bus.EX_RegWrite !== 1'b0 || bus.ID_Ready !== 1'b1) begin
            failures++; $display("FAIL flush_full got=%b/%b/%b exp=0/0/1", bus.EX_Valid, bus.EX_RegWrite, bus.ID_Ready);
        end
        drive(b, 1'b0);
        bus.EX_Ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus.EX_Valid !== 1'b0) begin failures++; $display("FAIL flush_ghost cyc=%0d got=%b exp=0", i, bus.EX_Valid); end
        end
        b = rand_bundle(); drive(b, 1'b1);
        step();
        b = rand_bundle(); b.rw = 1'b1; drive(b, 1'b1);
        bus.Flush = 1'b1;
        step();
        bus.Flush = 1'b0;
        drive(b, 1'b0);
        checks++;
        if (bus.EX_Valid !== 1'b0 || bus.EX_RegWrite !== 1'b0) begin failures++; $display("FAIL flush_accept got=%b/%b exp=0/0", bus.EX_Valid, bus.EX_RegWrite); end
        step();
        checks++;
        if (bus.EX_Valid !== 1'b0) begin failures++; $display("FAIL flush_accept_after got=%b exp=0", bus.EX_Valid); end
    endtask

    task automatic test_saturation();
        bundle_t b;
        Reset = 1'b1;
        drive(rand_bundle(), 1'b0);
        step();
        Reset = 1'b0;
        bus.EX_Ready = 1'b0;
        b = rand_bundle();
        drive(b, 1'b1);
        step();
        drive(b, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i >= 15) begin
                checks++;
                if (bus.EX_StallCount !== 4'd15) begin failures++; $display("FAIL sat_count cyc=%0d got=%0d exp=15", i, bus.EX_StallCount); end
                checks++;
                if (bus.EX_Valid !== 1'b1 || observed() !== b) begin failures++; $display("FAIL sat_stable cyc=%0d got=%h exp=%h", i, observed(), b); end
            end
        end
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        checks++;
        if (bus.EX_StallCount !== 4'd0 || bus.EX_Valid !== 1'b0) begin failures++; $display("FAIL sat_reset got=%0d/%b exp=0/0", bus.EX_StallCount, bus.EX_Valid); end
        bus.EX_Ready = 1'b1;
    endtask

    task automatic test_random();
        bundle_t b;
        bundle_t obs;
        for (int i = 0; i < 600; i++) begin
            Reset        = ($urandom_range(0, 63) == 0);
            bus.Flush    = ($urandom_range(0, 15) == 0);
            bus.EX_Ready = ($urandom_range(0, 2) != 0);
            b = rand_bundle();
            drive(b, ($urandom_range(0, 3) != 0));
            step();
            obs = observed();
            checks++;
            if (bus.EX_Valid !== (q.size() > 0)) begin failures++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", i, bus.EX_Valid, (q.size() > 0)); end
            checks++;
            if (bus.ID_Ready !== ((q.size() < 2) && !Reset)) begin failures++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", i, bus.ID_Ready, ((q.size() < 2) && !Reset)); end
            checks++;
            if (bus.EX_StallCount !== 4'(cntModel)) begin failures++; $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", i, bus.EX_StallCount, cntModel); end
            if (q.size() > 0) begin
                checks++;
                if (obs !== q[0]) begin failures++; $display("FAIL rand_payload cyc=%0d got=%h exp=%h", i, obs, q[0]); end
            end else begin
                checks++;
                if ({obs.rw, obs.rdst, obs.ma, obs.mb} !== 4'b0000) begin failures++; $display("FAIL rand_bubble cyc=%0d got=%b exp=0000", i, {obs.rw, obs.rdst, obs.ma, obs.mb}); end
            end
        end
        Reset     = 1'b0;
        bus.Flush = 1'b0;
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        cntModel     = 0;
        zeroB        = '0;
        Reset        = 1'b1;
        bus.Flush    = 1'b0;
        bus.EX_Ready = 1'b1;
        drive(zeroB, 1'b0);
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_ex_pipe_reg.md
# id_ex_pipe_reg

- Parametrised ID/EX pipeline register that moves decoded operands and control from the decode stage to the execute stage.
- Single rising-edge capture: 1-cycle latency, no negedge re-timing.
- Adds a valid/ready handshake through a two-entry skid buffer, so stalls and back-pressure lose no data.
- Adds flush (bubble injection) for branch/jump squash, and a saturating stall counter for performance monitoring.

## Interface
Parameters:
- DATA_W, 32, width of ReadData1/ReadData2/SignExtendOut/PCResult/Instruction
- ALUOP_W, 5, width of ALUInstruction
- CNT_W, 16, width of stall counter

Ports:
- Clk  in  1  clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high reset
- Flush  in  1  squash all held entries this cycle
- ID_Valid  in  1  decode presents a valid bundle
- ID_Ready  out  1  register can accept this cycle
- InstructionIn, PCResultIn, ReadData1In, ReadData2In, SignExtendOutIn  in  DATA_W each  data payload
- ALUInstructionIn  in  ALUOP_W  ALU operation
- RegWriteIn, RegDstIn, InputA_MuxSignalIn, InputB_MuxSignalIn  in  1 each  control payload
- EX_Valid  out  1  execute-side bundle valid
- EX_Ready  in  1  execute consumes bundle this cycle
- EX_Instruction, EX_PCResult, EX_ReadData1, EX_ReadData2, EX_SignExtendOut  out  DATA_W each
- EX_ALUInstruction  out  ALUOP_W
- EX_RegWrite, EX_RegDst, EX_InputA_MuxSignal, EX_InputB_MuxSignal  out  1 each
- EX_StallCount  out  CNT_W  cycles with EX_Valid=1 and EX_Ready=0; saturating

## Operation
- Storage:
  - Main entry M (valid bit + full payload) drives all EX_* outputs directly from registers.
  - Skid entry S (valid bit + payload) is internal only.
- Definitions:
  - accept = ID_Valid & ID_Ready
  - drain = M.valid & EX_Ready
  - m_free = ~M.valid | drain
- ID_Ready = ~S.valid & ~Reset. It is a function of registered state only; there is no combinational path from EX_Ready.
- Per-cycle update, in priority order:
  - Reset: M.valid=0, S.valid=0, all payload registers 0, EX_StallCount=0.
  - Flush: M.valid=0, S.valid=0. The incoming bundle is dropped even if ID_Valid=1. Payload registers are unchanged. The counter is unaffected.
  - m_free & S.valid: M <= S, S.valid <= 0. No accept is possible, since ID_Ready=0.
  - m_free & ~S.valid: M <= input bundle, M.valid <= accept.
  - ~m_free & accept: S <= input bundle, S.valid <= 1.
  - Otherwise: hold.
- Bubble gating:
  - When EX_Valid=0, EX_RegWrite, EX_RegDst, EX_InputA_MuxSignal and EX_InputB_MuxSignal read 0. This is an AND with M.valid.
  - Data fields show stale contents and are don't-care.
- Ordering: strictly FIFO. S never holds a bundle older than M.
- Counter:
  - Increments by 1 when M.valid & ~EX_Ready & ~Flush & ~Reset.
  - Saturates at 2^CNT_W-1. No wrap.
- Only Reset clears the counter.

## Timing
- Reset values:
  - EX_Valid=0, ID_Ready=0 while Reset=1, ID_Ready=1 on the first cycle after Reset deasserts.
  - All EX_* payload outputs 0; EX_StallCount=0.
- Latency: a bundle accepted at edge N appears with EX_Valid=1 after edge N when M was free.
- Throughput: 1 bundle/cycle while EX_Ready=1.
- Back-pressure:
  - After EX_Ready drops, at most one further bundle is absorbed, into S.
  - ID_Ready deasserts the cycle after S fills.
  - ID_Ready reasserts the cycle after S drains into M.
- Simultaneous Flush with accept: Flush wins and the bundle is lost. Upstream must treat it as squashed.
- Reset asserted mid-stream or during Flush: Reset wins. State is cleared on that edge.
- EX_Valid must not drop without drain or Flush/Reset. Payload must be stable while EX_Valid=1 and EX_Ready=0.

## Test plan
- Reset sequencing:
  - Stimulus: hold Reset 3 cycles with ID_Valid=1 and nonzero payload.
  - Required: EX_Valid=0, all outputs 0, ID_Ready=0; after release ID_Ready=1 and nothing is captured from the reset cycles.
- Streaming:
  - Stimulus: EX_Ready=1; push PCResultIn=0x0,0x4,0x8,0xC on consecutive cycles.
  - Required: EX_PCResult shows the same sequence, 1 cycle later, with no gaps.
- Back-pressure:
  - Stimulus: stream 0x10,0x14,0x18; drop EX_Ready for 3 cycles after 0x10 appears.
  - Required:
    - 0x14 is held in S and ID_Ready=0.
    - 0x18 is held upstream.
    - After EX_Ready=1 the output order is 0x10,0x14,0x18.
    - EX_StallCount=3.
- Flush with full skid:
  - Stimulus: fill M and S with RegWriteIn=1; assert Flush together with ID_Valid=1.
  - Required: next cycle EX_Valid=0, EX_RegWrite=0, ID_Ready=1; no flushed bundle ever appears.
- Counter saturation:
  - Stimulus: CNT_W=4; hold EX_Valid=1, EX_Ready=0 for 20 cycles.
  - Required: EX_StallCount=15 and stays there; Reset returns it to 0.
